// File: rtl/bridge_ahb_slave_if.sv
// AHB-Lite slave front end of the AHB2APB bridge: qualify, decode, track bursts, ERROR response.
// Optional BURST_WRAP_EN: WRAP4/8/16 bursts wrap INC_ADDR at the burst boundary.
module bridge_ahb_slave_if #(
  parameter int WIDTH      = 32,
  parameter int SLAVES     = 4,
  parameter int REGION_LSB = 12
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [WIDTH-1:0] HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [2:0]       HBURST,
  input  logic             HREADY_IN,
  input  logic             HREADY_APB,
  output logic             valid,
  output logic [WIDTH-1:0] HADDR_REG_D1,
  output logic [WIDTH-1:0] HADDR_REG_D2,
  output logic [WIDTH-1:0] HADDR_REG_D3,
  output logic [WIDTH-1:0] INC_ADDR,
  output logic             flag_timer,
  output logic             flag_interruptc,
  output logic             flag_remap_pause_controller,
  output logic             flag_slave4,
  output logic             HREADY,
  output logic             HRESP
);

  typedef enum logic [1:0] {
    S_OK,
    S_ERR1,
    S_ERR2
  } err_e;

  err_e st_q, st_d;

  logic [WIDTH-1:0]  d1_q, d1_d;
  logic [WIDTH-1:0]  d2_q, d3_q;
  logic [WIDTH-1:0]  inc_q, inc_d;
  logic [SLAVES-1:0] flag_q, flag_d;

  logic             qual;
  logic             bad;
  logic             ill;
  logic             acc;
  logic             hw_unused;
  logic [3:0]       region;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] nxt;

  assign hw_unused = HWRITE;
  assign region    = HADDR[REGION_LSB+3:REGION_LSB];
  assign step      = WIDTH'(1) << HSIZE;
  assign qual      = HSEL & HREADY_IN & HTRANS[1];

  assign bad = (HSIZE > 3'b010)
             | (|(HADDR & (step - WIDTH'(1))))
             | (int'(region) >= SLAVES);

  // ERR1 stalls the master, so nothing presented then is looked at.
  assign ill   = qual & bad & (st_q != S_ERR1);
  assign acc   = qual & ~bad & (st_q != S_ERR1);
  assign valid = acc;

  // SEQ beats off the predicted address re-sync to HADDR.
  always_comb begin
    base = HADDR;
    if (HTRANS == 2'b11 && HADDR == inc_q) begin
      base = inc_q;
    end
  end

`ifdef BURST_WRAP_EN
  logic [WIDTH-1:0] mask;
  logic             wrap;

  always_comb begin
    mask = '0;
    wrap = 1'b0;
    unique case (1'b1)
      (HBURST == 3'b010): begin
        wrap = 1'b1;
        mask = (step << 2) - WIDTH'(1);
      end
      (HBURST == 3'b100): begin
        wrap = 1'b1;
        mask = (step << 3) - WIDTH'(1);
      end
      (HBURST == 3'b110): begin
        wrap = 1'b1;
        mask = (step << 4) - WIDTH'(1);
      end
      default: begin
        wrap = 1'b0;
      end
    endcase
    nxt = base + step;
    if (wrap) begin
      nxt = (base & ~mask) | ((base + step) & mask);
    end
  end
`else
  logic [2:0] hb_unused;
  assign hb_unused = HBURST;
  assign nxt       = base + step;
`endif

  always_comb begin
    st_d   = st_q;
    HREADY = HREADY_APB;
    HRESP  = 1'b0;
    unique case (st_q)
      S_OK: begin
        if (ill) st_d = S_ERR1;
      end
      S_ERR1: begin
        st_d   = S_ERR2;
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      S_ERR2: begin
        st_d   = ill ? S_ERR1 : S_OK;
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        st_d = S_OK;
      end
    endcase
  end

  always_comb begin
    d1_d   = d1_q;
    inc_d  = inc_q;
    flag_d = flag_q;
    if (ill) begin
      flag_d = '0;
    end else if (acc) begin
      d1_d  = HADDR;
      inc_d = nxt;
      for (int i = 0; i < SLAVES; i++) begin
        flag_d[i] = (int'(region) == i);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st_q   <= S_OK;
      d1_q   <= '0;
      d2_q   <= '0;
      d3_q   <= '0;
      inc_q  <= '0;
      flag_q <= '0;
    end else begin
      st_q   <= st_d;
      d1_q   <= d1_d;
      inc_q  <= inc_d;
      flag_q <= flag_d;
      if (HREADY_IN) begin
        d2_q <= d1_q;
        d3_q <= d2_q;
      end
    end
  end

  assign HADDR_REG_D1 = d1_q;
  assign HADDR_REG_D2 = d2_q;
  assign HADDR_REG_D3 = d3_q;
  assign INC_ADDR     = inc_q;

  assign flag_timer                  = flag_q[0];
  assign flag_interruptc             = flag_q[1];
  assign flag_remap_pause_controller = flag_q[2];
  assign flag_slave4                 = flag_q[3];

endmodule
